// File: rtl/avmm_csr_initiator_if.sv
// CSR initiator bus bundle: command/response stream plus Avalon-MM master signals.
// The master modport is the initiator's view; the slave modport is the host/fabric view.
interface avmm_csr_initiator_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    // Command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    // Response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // Avalon-MM master
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  avm_readdata, avm_waitrequest,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output avm_address, avm_read, avm_write, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output avm_readdata, avm_waitrequest,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  avm_address, avm_read, avm_write, avm_writedata
    );
endinterface

// File: rtl/avmm_csr_initiator.sv
// Single-outstanding CSR command -> Avalon-MM read/write initiator.
// Optional watchdog enabled by defining AVMM_CSR_INITIATOR_TIMEOUT_EN: a transaction
// stalled on waitrequest for TIMEOUT_CYCLES cycles is aborted with rsp_err=1.
module avmm_csr_initiator #(
    parameter int unsigned       ADDR_W         = 16,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                        clk_csr_clk,
    input  logic                        csr_reset,
    avmm_csr_initiator_if.master        bus,
    output logic [15:0]                 timeout_cnt
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || $bits(TIMEOUT_RDATA) != DATA_W)
    begin : g_bad_param
        $error("avmm_csr_initiator: illegal TIMEOUT_CYCLES or TIMEOUT_RDATA width");
    end

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_t;

    state_t            state;
    logic              cmd_ready_q;
    logic              is_write_q;
    logic [ADDR_W-1:0] avm_address_q;
    logic [DATA_W-1:0] avm_writedata_q;
    logic              avm_read_q;
    logic              avm_write_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [15:0]       wait_cnt_q;
    logic [15:0]       timeout_q;

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.avm_address   = avm_address_q;
    assign bus.avm_writedata = avm_writedata_q;
    assign bus.avm_read      = avm_read_q;
    assign bus.avm_write     = avm_write_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    // Only ever set in the watchdog build; constant zero otherwise.
    assign bus.rsp_err       = rsp_err_q;
    assign timeout_cnt       = timeout_q;

    // Transaction FSM with all bus and response outputs registered.
    always_ff @(posedge clk_csr_clk) begin
        if (csr_reset) begin
            state           <= StIdle;
            cmd_ready_q     <= 1'b0;
            is_write_q      <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_write_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
            wait_cnt_q      <= '0;
            timeout_q       <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q     <= 1'b0;
                        is_write_q      <= bus.cmd_write;
                        avm_address_q   <= bus.cmd_addr;
                        avm_writedata_q <= bus.cmd_wdata;
                        avm_read_q      <= ~bus.cmd_write;
                        avm_write_q     <= bus.cmd_write;
                        wait_cnt_q      <= '0;
                        state           <= StBus;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                StBus: begin
                    if (!bus.avm_waitrequest) begin
                        // Normal completion also wins over a same-cycle watchdog expiry.
                        avm_read_q  <= 1'b0;
                        avm_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= is_write_q;
                        rsp_rdata_q <= is_write_q ? '0 : bus.avm_readdata;
                        rsp_err_q   <= 1'b0;
                        state       <= StResp;
                    end else begin
                        if (wait_cnt_q != 16'hFFFF) begin
                            wait_cnt_q <= wait_cnt_q + 16'd1;
                        end
`ifdef AVMM_CSR_INITIATOR_TIMEOUT_EN
                        // This stall cycle is the TIMEOUT_CYCLES-th one: abort.
                        if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                            avm_read_q  <= 1'b0;
                            avm_write_q <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_write_q <= is_write_q;
                            rsp_rdata_q <= is_write_q ? '0 : TIMEOUT_RDATA;
                            rsp_err_q   <= 1'b1;
                            if (timeout_q != 16'hFFFF) begin
                                timeout_q <= timeout_q + 16'd1;
                            end
                            state       <= StResp;
                        end
`endif
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_csr_initiator.sv
// Directed self-checking bench for avmm_csr_initiator.
module tb_avmm_csr_initiator;

`ifdef AVMM_CSR_INITIATOR_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1024;
`endif

    logic        clk_csr_clk = 1'b0;
    logic        csr_reset;
    logic [15:0] timeout_cnt;
    logic        model_en;
    logic [31:0] rdata_drv;
    int          errors = 0;
    int          checks = 0;
    bit          seen;

    avmm_csr_initiator_if #(.ADDR_W(16), .DATA_W(32)) bus_if ();

    avmm_csr_initiator #(
        .ADDR_W        (16),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk_csr_clk(clk_csr_clk),
        .csr_reset  (csr_reset),
        .bus        (bus_if),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk_csr_clk = ~clk_csr_clk;

    // Slave read-data model: address-tagged data, or a directly driven value.
    always_comb begin
        bus_if.avm_readdata = model_en ? {16'hC0DE, bus_if.avm_address} : rdata_drv;
    end

    task automatic step();
        @(posedge clk_csr_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        csr_reset              = 1'b1;
        model_en               = 1'b0;
        rdata_drv              = '0;
        bus_if.cmd_valid       = 1'b0;
        bus_if.cmd_write       = 1'b0;
        bus_if.cmd_addr        = '0;
        bus_if.cmd_wdata       = '0;
        bus_if.rsp_ready       = 1'b0;
        bus_if.avm_waitrequest = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_cmd_ready", bus_if.cmd_ready, 0);
        chk("rst_rsp_valid", bus_if.rsp_valid, 0);
        chk("rst_avm_rw", {bus_if.avm_read, bus_if.avm_write}, 0);
        chk("rst_avm_addr", bus_if.avm_address, 0);
        chk("rst_rsp_rdata", bus_if.rsp_rdata, 0);
        chk("rst_timeout_cnt", timeout_cnt, 0);
        csr_reset = 1'b0;
        step();
        chk("post_rst_cmd_ready", bus_if.cmd_ready, 1);

        // Write, no stall
        bus_if.rsp_ready = 1'b1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 16'h1000;
        bus_if.cmd_wdata = 32'hA5A5_0001;
        step();
        bus_if.cmd_valid = 1'b0;
        chk("wr_avm_write", {bus_if.avm_read, bus_if.avm_write}, 2'b01);
        chk("wr_avm_addr", bus_if.avm_address, 16'h1000);
        chk("wr_avm_wdata", bus_if.avm_writedata, 32'hA5A5_0001);
        chk("wr_cmd_ready_busy", bus_if.cmd_ready, 0);
        chk("wr_rsp_early", bus_if.rsp_valid, 0);
        step();
        chk("wr_avm_drop", {bus_if.avm_read, bus_if.avm_write}, 0);
        chk("wr_rsp_valid", bus_if.rsp_valid, 1);
        chk("wr_rsp_fields", {bus_if.rsp_write, bus_if.rsp_err, bus_if.rsp_rdata}, {2'b10, 32'h0});
        step();
        chk("wr_rsp_done", bus_if.rsp_valid, 0);
        chk("wr_cmd_ready_again", bus_if.cmd_ready, 1);

        // Read with a 5-cycle stall, response held off afterwards
        bus_if.rsp_ready       = 1'b0;
        bus_if.avm_waitrequest = 1'b1;
        bus_if.cmd_valid       = 1'b1;
        bus_if.cmd_write       = 1'b0;
        bus_if.cmd_addr        = 16'h4008;
        step();
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rd_stall_held", {bus_if.avm_read, bus_if.avm_write, bus_if.avm_address},
                {2'b10, 16'h4008});
            step();
        end
        bus_if.avm_waitrequest = 1'b0;
        rdata_drv              = 32'h1234_5678;
        chk("rd_6th_cycle", {bus_if.avm_read, bus_if.avm_address}, {1'b1, 16'h4008});
        step();
        rdata_drv = 32'h0BAD_0BAD;
        chk("rd_avm_drop", bus_if.avm_read, 0);
        chk("rd_rsp", {bus_if.rsp_valid, bus_if.rsp_write, bus_if.rsp_err, bus_if.rsp_rdata},
            {3'b100, 32'h1234_5678});

        // Response backpressure with a second command waiting
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 16'h2000;
        bus_if.cmd_wdata = 32'h0000_2222;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!(bus_if.rsp_valid && bus_if.rsp_rdata == 32'h1234_5678 && !bus_if.cmd_ready
                  && !bus_if.avm_write)) seen = 1'b1;
        end
        chk("bp_stable", seen, 0);
        bus_if.rsp_ready = 1'b1;
        step();
        chk("bp_handshake", {bus_if.rsp_valid, bus_if.cmd_ready, bus_if.avm_write}, 3'b010);
        step();
        bus_if.cmd_valid = 1'b0;
        chk("bp_second_accept", {bus_if.avm_write, bus_if.cmd_ready, bus_if.avm_address},
            {2'b10, 16'h2000});
        step();
        chk("bp_second_rsp", {bus_if.rsp_valid, bus_if.rsp_write}, 2'b11);
        step();

        // Back-to-back reads, one per 3 cycles
        model_en         = 1'b1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_if.cmd_addr = 16'(k * 4);
            step();
            chk("b2b_read", {bus_if.avm_read, bus_if.avm_address}, {1'b1, 16'(k * 4)});
            step();
            chk("b2b_rsp", {bus_if.rsp_valid, bus_if.rsp_rdata}, {1'b1, 16'hC0DE, 16'(k * 4)});
            step();
            chk("b2b_ready", {bus_if.rsp_valid, bus_if.cmd_ready}, 2'b01);
        end
        bus_if.cmd_valid = 1'b0;
        model_en         = 1'b0;

        // Waitrequest stuck high
        bus_if.avm_waitrequest = 1'b1;
        bus_if.cmd_valid       = 1'b1;
        bus_if.cmd_addr        = 16'h0010;
        step();
        bus_if.cmd_valid = 1'b0;
`ifdef AVMM_CSR_INITIATOR_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (!bus_if.avm_read || bus_if.rsp_valid) seen = 1'b1;
        end
        chk("wd_held", seen, 0);
        step();
        chk("wd_abort", {bus_if.avm_read, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata},
            {3'b011, 32'hDEAD_BEEF});
        chk("wd_count", timeout_cnt, 1);
        step();
        chk("wd_rsp_done", bus_if.rsp_valid, 0);
        step();
`else
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus_if.rsp_valid || !bus_if.avm_read) seen = 1'b1;
        end
        chk("hang_no_rsp", seen, 0);
        chk("hang_no_err", {bus_if.rsp_err, timeout_cnt}, 0);
        csr_reset = 1'b1;
        step();
        csr_reset = 1'b0;
        step();
`endif

        // Reset mid-BUS during a stalled write
        chk("rst2_idle_ready", bus_if.cmd_ready, 1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 16'h3000;
        step();
        bus_if.cmd_valid = 1'b0;
        step();
        step();
        chk("rst2_stalled", bus_if.avm_write, 1);
        csr_reset = 1'b1;
        step();
        chk("rst2_dropped", {bus_if.avm_write, bus_if.rsp_valid, bus_if.cmd_ready}, 0);
        csr_reset              = 1'b0;
        bus_if.avm_waitrequest = 1'b0;
        step();
        chk("rst2_ready", bus_if.cmd_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus_if.rsp_valid || bus_if.avm_write || bus_if.avm_read) seen = 1'b1;
        end
        chk("rst2_no_spurious", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avmm_csr_initiator.md
Name: avmm_csr_initiator

Overview:
- Avalon-MM initiator that converts a single-outstanding CSR command/response stream (host MMIO path) into Avalon-MM read/write transactions.
- Drives the 16-bit-address, 32-bit-data master port feeding the e10 CSR address decoder (eth_gen_mon, mac, phy, rx/tx sc_fifo slaves).
- Honours waitrequest, captures readdata, and returns a response with error status.
- Optionally includes a watchdog that aborts hung transactions.

Parameters:
- ADDR_W, 16, Avalon address width in bits.
- DATA_W, 32, Avalon and command data width in bits.
- TIMEOUT_CYCLES, 1024, maximum cycles a transaction may stall on waitrequest (used only with the watchdog); legal range 2..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, readdata returned on an aborted read.

Ports:
- clk_csr_clk  in  1  CSR clock; all logic is on its rising edge.
- csr_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  echo of the command type.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transaction aborted by the watchdog.
- avm_address  out  ADDR_W  Avalon address.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  DATA_W  Avalon write data.
- avm_readdata  in  DATA_W  Avalon read data, valid in the cycle waitrequest is low during a read.
- avm_waitrequest  in  1  Avalon stall.
- timeout_cnt  out  16  saturating count of aborted transactions.

Behaviour:
- Reset (synchronous, csr_reset=1 at a clock edge):
  - state=IDLE.
  - cmd_ready=0 in the reset cycle; 1 from the first cycle after reset deasserts.
  - rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0.
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0.
  - timeout_cnt=0, internal wait counter=0.
  - Reset mid-transaction drops the bus command in the next cycle and generates no response.
- States:
  - IDLE: cmd_ready=1. On accept, latch cmd_write/addr/wdata, drive avm_address/avm_writedata, assert avm_read or avm_write (registered, so visible the cycle after accept), clear wait counter, go to BUS.
  - BUS: hold address, data and read/write stable while avm_waitrequest=1. In the first cycle with avm_waitrequest=0:
    - deassert avm_read/avm_write next cycle;
    - for a read, capture avm_readdata into rsp_rdata; for a write, rsp_rdata=0;
    - rsp_err=0, rsp_valid=1, go to RESP.
  - RESP: hold rsp_* stable until rsp_ready=1; then rsp_valid=0 and go to IDLE. cmd_ready is asserted the cycle after the response handshake.
- Exactly one transaction is outstanding; cmd_ready=0 in BUS and RESP.
- Minimum latency: accept at cycle 0 → avm_* asserted at cycle 1 → waitrequest low at cycle 1 → rsp_valid at cycle 2.
- Minimum throughput: one transaction per 3 cycles when rsp_ready is held high.
- avm_read and avm_write are never both 1. Neither is asserted outside BUS.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Wait counter counts BUS cycles with waitrequest=1 and saturates at 16 bits.

Optional Feature:
- Macro AVMM_CSR_INITIATOR_TIMEOUT_EN.
- Defined:
  - If the wait counter reaches TIMEOUT_CYCLES while waitrequest is still 1, deassert avm_read/avm_write next cycle and enter RESP with rsp_err=1.
  - rsp_rdata = TIMEOUT_RDATA for reads, 0 for writes.
  - timeout_cnt increments and saturates at 16'hFFFF.
  - If waitrequest falls in the same cycle the counter reaches the limit, normal completion wins (rsp_err=0).
- Not defined: BUS waits indefinitely, rsp_err is tied to 0, and timeout_cnt is tied to 0.

Test Plan:
- Write, no stall: cmd write addr=16'h1000 wdata=32'hA5A5_0001, waitrequest=0 → avm_write=1 for exactly 1 cycle with those values; rsp_valid 2 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read with 5-cycle stall: cmd read addr=16'h4008, waitrequest=1 for 5 cycles then 0 with readdata=32'h1234_5678 → avm_read held 6 cycles with stable address; rsp_rdata=32'h1234_5678.
- Response backpressure: rsp_ready=0 for 10 cycles → rsp_* stable, cmd_ready=0 throughout; a second cmd_valid is not accepted until 1 cycle after the rsp handshake.
- Back-to-back: 4 reads to 16'h0000/0004/0008/000C with rsp_ready=1 and waitrequest=0 → 4 responses in order, one per 3 cycles, data matching the slave model.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): read with waitrequest stuck at 1 → avm_read drops after 16 stall cycles; rsp_err=1, rsp_rdata=32'hDEAD_BEEF, timeout_cnt=1. Without the macro: no response after 1000 cycles.
- Reset mid-BUS: assert csr_reset during a stalled write → next cycle avm_write=0, rsp_valid=0, cmd_ready=1 after reset deasserts; no spurious response.
